// File: rtl/key_debounce8.sv
// Eight-channel key synchronizer/debouncer feeding an active-low priority encoder.
// Two-flop sync, shared tick prescaler, per-channel stability counters and strobes.
module key_debounce8 #(
   parameter int TICK_DIV = 50000,
   parameter int STABLE_N = 16
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [7:0] KeyIn,
   output logic [7:0] KeyOut,
   output logic [7:0] KeyPress,
   output logic [7:0] KeyRelease
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_N - 1);

   logic [7:0]         sync1_q, sync2_q;
   logic [DW-1:0]      div_q, div_d;
   logic [7:0][CW-1:0] cnt_q, cnt_d;
   logic [7:0]         key_q, key_d;
   logic [7:0]         press_q, press_d;
   logic [7:0]         rel_q, rel_d;
   logic               tick;

   assign tick = (div_q == DIV_MAX);

   always_comb begin
      div_d   = tick ? '0 : div_q + DW'(1);
      key_d   = key_q;
      press_d = '0;
      rel_d   = '0;
      cnt_d   = cnt_q;
      for (int i = 0; i < 8; i++) begin
         // A bounce back to the current level restarts qualification.
         if (sync2_q[i] == key_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == CNT_MAX) begin
               key_d[i]   = sync2_q[i];
               cnt_d[i]   = '0;
               press_d[i] = ~sync2_q[i];
               rel_d[i]   = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync1_q <= 8'hFF;
         sync2_q <= 8'hFF;
         div_q   <= '0;
         cnt_q   <= '0;
         key_q   <= 8'hFF;
         press_q <= 8'h00;
         rel_q   <= 8'h00;
      end else begin
         sync1_q <= KeyIn;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign KeyOut     = key_q;
   assign KeyPress   = press_q;
   assign KeyRelease = rel_q;

endmodule

// File: tb/tb_key_debounce8.sv
// Directed bench for key_debounce8 with TICK_DIV=4, STABLE_N=3.
// Hand-computed levels, strobe masks and latency windows.
module tb_key_debounce8;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic [7:0] KeyIn = 8'h00;
   logic [7:0] KeyOut, KeyPress, KeyRelease;
   int         errs = 0;
   int         checks = 0;

   key_debounce8 #(.TICK_DIV(4), .STABLE_N(3)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .KeyIn      (KeyIn),
      .KeyOut     (KeyOut),
      .KeyPress   (KeyPress),
      .KeyRelease (KeyRelease)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Model of a 74HC148 fed by KeyOut: index of highest active-low input.
   function automatic logic [7:0] enc_idx(input logic [7:0] k);
      logic [7:0] r;
      r = 8'hFF;
      for (int i = 0; i < 8; i++)
         if (!k[i]) r = 8'(i);
      return r;
   endfunction

   // Waits for KeyOut to change, then checks value, strobes and latency.
   task automatic wait_flip(input string tag, input logic [7:0] eout,
                            input logic [7:0] epr, input logic [7:0] erl,
                            input int lo, input int hi);
      logic [7:0] prev;
      logic       early;
      int         n;
      prev  = KeyOut;
      early = 1'b0;
      n     = 0;
      while (n < hi + 4) begin
         step();
         n++;
         if (KeyOut !== prev) break;
         if ((KeyPress | KeyRelease) != 8'h00) early = 1'b1;
      end
      chk({tag, "_out"}, KeyOut, eout);
      chk({tag, "_press"}, KeyPress, epr);
      chk({tag, "_rel"}, KeyRelease, erl);
      chk({tag, "_early"}, {7'd0, early}, 8'h00);
      chk({tag, "_lat_ok"}, {7'd0, (n >= lo && n <= hi)}, 8'h01);
      step();
      chk({tag, "_press_1cy"}, KeyPress, 8'h00);
      chk({tag, "_rel_1cy"}, KeyRelease, 8'h00);
      chk({tag, "_hold"}, KeyOut, eout);
   endtask

   initial begin
      logic [7:0] acc_out, acc_strb;

      // Reset held with all keys pressed.
      repeat (3) step();
      chk("rst_out", KeyOut, 8'hFF);
      chk("rst_press", KeyPress, 8'h00);
      chk("rst_rel", KeyRelease, 8'h00);
      Rst_n = 1'b1;
      wait_flip("rst_all", 8'h00, 8'hFF, 8'h00, 10, 14);

      KeyIn = 8'hFF;
      wait_flip("rel_all", 8'hFF, 8'h00, 8'hFF, 11, 14);

      // Clean press/release on bit 3.
      KeyIn = 8'hF7;
      wait_flip("b3_press", 8'hF7, 8'h08, 8'h00, 11, 14);
      KeyIn = 8'hFF;
      wait_flip("b3_rel", 8'hFF, 8'h00, 8'h08, 11, 14);

      // Bounce on bit 7: 5-cycle segments never qualify.
      acc_out  = 8'hFF;
      acc_strb = 8'h00;
      for (int s = 0; s < 8; s++) begin
         KeyIn[7] = s[0];
         for (int c = 0; c < 5; c++) begin
            step();
            acc_out  = acc_out & KeyOut;
            acc_strb = acc_strb | KeyPress | KeyRelease;
         end
      end
      chk("bounce_out", acc_out, 8'hFF);
      chk("bounce_strb", acc_strb, 8'h00);
      KeyIn[7] = 1'b0;
      wait_flip("b7_press", 8'h7F, 8'h80, 8'h00, 11, 14);
      KeyIn = 8'hFF;
      wait_flip("b7_rel", 8'hFF, 8'h00, 8'h80, 11, 14);

      // Simultaneous keys flip together.
      KeyIn = 8'h5A;
      wait_flip("multi", 8'h5A, 8'hA5, 8'h00, 11, 14);
      chk("enc_idx", enc_idx(KeyOut), 8'd7);
      KeyIn = 8'hFF;
      wait_flip("multi_rel", 8'hFF, 8'h00, 8'hA5, 11, 14);

      // Mid-qualification reset: two ticks of progress, then discarded.
      KeyIn = 8'hFE;
      acc_strb = 8'h00;
      for (int c = 0; c < 10; c++) begin
         step();
         acc_strb = acc_strb | KeyPress | KeyRelease;
      end
      chk("mid_pre_out", KeyOut, 8'hFF);
      chk("mid_pre_strb", acc_strb, 8'h00);
      Rst_n = 1'b0;
      #1;
      chk("mid_rst_out", KeyOut, 8'hFF);
      step();
      Rst_n = 1'b1;
      wait_flip("mid_requal", 8'hFE, 8'h01, 8'h00, 10, 14);
      KeyIn = 8'hFF;
      wait_flip("mid_rel", 8'hFF, 8'h00, 8'h01, 11, 14);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/key_debounce8.md
# key_debounce8

Eight-channel key synchronizer and debouncer driving the active-low `DataIn[7:0]` bus of the 74HC148-style priority encoder. Raw, bouncing, asynchronous active-low key lines enter; clean, glitch-free, clock-domain-aligned active-low levels leave, together with one-cycle press/release strobes per key. `KeyOut` connects bit-for-bit to the encoder's `DataIn`, so bit 7 keeps the highest priority downstream.

## Interface
- `TICK_DIV`, 50000: clock cycles per debounce sample tick; legal range ≥2.
- `STABLE_N`, 16: consecutive mismatching ticks required before an output flips; legal range ≥2.
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously with `Clk` at system level.
- `KeyIn`  in  8  raw key lines, active-low (0 = pressed), asynchronous to `Clk`.
- `KeyOut`  out  8  debounced key levels, active-low, registered; feeds encoder `DataIn`.
- `KeyPress`  out  8  one-cycle high strobe when `KeyOut[i]` falls 1→0.
- `KeyRelease`  out  8  one-cycle high strobe when `KeyOut[i]` rises 0→1.

## Operation
- **Reset values (while `Rst_n`=0).**
  - Both synchronizer stages = 8'hFF.
  - `KeyOut` = 8'hFF.
  - `KeyPress` = `KeyRelease` = 8'h00.
  - Prescaler = 0; all per-channel counters = 0.
- **Synchronizer.** Two flops per bit: `s1 <= KeyIn`, `s2 <= s1`. Only `s2` is used downstream.
- **Prescaler.**
  - Shared counter `div`, 0..TICK_DIV-1, wraps to 0.
  - `tick` = (`div` == TICK_DIV-1) is combinational and asserts for exactly one cycle in every TICK_DIV.
- **Per-channel counter.** `cnt[i]` is ceil(log2(STABLE_N)) bits wide. Each cycle:
  - If `s2[i]` == `KeyOut[i]`: `cnt[i]` <= 0, regardless of `tick`. Any bounce back restarts qualification.
  - Else if `tick` and `cnt[i]` < STABLE_N-1: `cnt[i]` <= `cnt[i]`+1.
  - Else if `tick` and `cnt[i]` == STABLE_N-1:
    - `KeyOut[i]` <= `s2[i]`, `cnt[i]` <= 0.
    - `KeyPress[i]` <= ~`s2[i]`, `KeyRelease[i]` <= `s2[i]`.
  - Else: hold.
- **Strobes.**
  - Registered and high only in the cycle where `KeyOut[i]` shows its new value. They default to 0 every other cycle.
  - `KeyPress[i]` and `KeyRelease[i]` are never both high.
- **Channel independence.** Channels are fully independent. Any number of channels may flip on the same tick, and the encoder resolves priority downstream.
- **Counter range.** No counter saturates or wraps past STABLE_N-1.

## Timing
- A raw edge on `KeyIn[i]` reaches `s2[i]` after 2 rising edges.
- Output flips on the STABLE_N-th tick seen while `s2[i]` != `KeyOut[i]` continuously.
- Latency from `s2` change to `KeyOut` change: min (STABLE_N-1)·TICK_DIV+1 cycles, max STABLE_N·TICK_DIV cycles.
- A pulse on `KeyIn` lasting fewer than (STABLE_N-1)·TICK_DIV cycles never reaches `KeyOut`.
- **Mid-operation reset.** Asserting `Rst_n` mid-qualification discards progress. After release, a held key needs a full qualification from a fresh prescaler phase.
- **Press during reset.**
  - A key held low through reset deassertion produces `KeyPress` after qualification.
  - `KeyOut` must not be 0 before then.
- **Encoder timing.** `KeyOut` changes only on `Clk` edges, so encoder outputs settle within one cycle of combinational delay.

## Test plan
Bench parameters: TICK_DIV=4, STABLE_N=3.

- **Reset.** Hold `Rst_n`=0 with `KeyIn`=8'h00 → `KeyOut`=8'hFF, strobes 8'h00. Release and keep `KeyIn`=8'h00 → `KeyOut`=8'h00 and `KeyPress`=8'hFF for exactly one cycle, 10–14 cycles after release.
- **Clean press/release on bit 3.**
  - `KeyIn`=8'hF7 held → `KeyOut`=8'hF7 within 2+9..2+12 cycles, with `KeyPress`=8'h08 for one cycle.
  - Return to 8'hFF → `KeyOut`=8'hFF with `KeyRelease`=8'h08 for one cycle.
- **Bounce on bit 7.** Toggle `KeyIn[7]` low/high every 5 cycles for 40 cycles → `KeyOut` stays 8'hFF, no strobes. Then hold low → single `KeyPress`=8'h80.
- **Simultaneous keys.** `KeyIn` 8'hFF→8'h5A in one cycle → `KeyOut`=8'h5A in a single cycle, `KeyPress`=8'hA5. Encoder fed by `KeyOut` outputs the code for bit 7.
- **Mid-qualification reset.** Press bit 0, pulse `Rst_n` low for 1 cycle after 2 ticks → no strobe before a full 3-tick requalification after release. `KeyOut` = 8'hFF until then.
